// File: rtl/noc_output_port.sv
// Per-direction output stage of the 5-port mesh router: registers the granted
// flit, tracks downstream credits and rotates the round-robin turn vector.
module noc_output_port #(
  parameter int DATA_W  = 8,
  parameter int CREDITS = 4,
  parameter int CNT_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5*DATA_W-1:0] in_data_i,
  input  logic [4:0]        req_i,
  input  logic [2:0]        port_select_i,
  input  logic              port_enable_i,
  input  logic              credit_inc_i,
  output logic              port_full_o,
  output logic [4:0]        turn_o,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              err_o
);

  // Handshake: a flit moves when port_enable_i is high at a rising edge and
  // the grant is legal (not full, source in range, source owns the turn);
  // valid_o then pulses for exactly one cycle with data_o holding the flit.

  localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(CREDITS);
  localparam logic [4:0]       TURN_N   = 5'b10000;

  logic [CNT_W-1:0]  credits;
  logic [4:0]        turn_next;
  logic [2:0]        owner;
  logic              owner_req;
  logic              sel_ok;
  logic              legal;
  logic              illegal_en;
  logic              inc_sat;
  logic [DATA_W-1:0] sel_flit;

  // turn state register
  always_ff @(posedge clk) begin
    if (rst) turn_o <= TURN_N;
    else     turn_o <= turn_next;
  end

  // turn next-state: advance on a grant or when the owner is idle
  always_comb begin
    turn_next = turn_o;
    if (legal || !owner_req) turn_next = {turn_o[0], turn_o[4:1]};
  end

  // turn outputs: owner index and its request bit (turn bit 4-k belongs to input k)
  always_comb begin
    owner = 3'd0;
    for (int k = 0; k < 5; k++) begin
      if (turn_o[4-k]) owner = 3'(k);
    end
  end
  assign owner_req = |(turn_o & {req_i[0], req_i[1], req_i[2], req_i[3], req_i[4]});

  always_comb begin
    sel_flit = '0;
    case (port_select_i)
      3'd0:    sel_flit = in_data_i[0*DATA_W +: DATA_W];
      3'd1:    sel_flit = in_data_i[1*DATA_W +: DATA_W];
      3'd2:    sel_flit = in_data_i[2*DATA_W +: DATA_W];
      3'd3:    sel_flit = in_data_i[3*DATA_W +: DATA_W];
      3'd4:    sel_flit = in_data_i[4*DATA_W +: DATA_W];
      default: sel_flit = '0;
    endcase
  end

  assign port_full_o = (credits == '0);
  assign sel_ok      = (port_select_i <= 3'd4) && (port_select_i == owner);
  assign legal       = port_enable_i && !port_full_o && sel_ok;
  assign illegal_en  = port_enable_i && !legal;
  assign inc_sat     = credit_inc_i && !legal && (credits == CRED_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      data_o  <= '0;
      valid_o <= 1'b0;
      credits <= CRED_MAX;
      err_o   <= 1'b0;
    end else begin
      valid_o <= legal;
      if (legal) data_o <= sel_flit;
      // grant and return in the same cycle cancel out
      if (legal && !credit_inc_i)                  credits <= credits - CNT_W'(1);
      else if (credit_inc_i && !legal && !inc_sat) credits <= credits + CNT_W'(1);
      if (illegal_en || inc_sat) err_o <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert ($onehot(turn_o));
  end

endmodule

// File: tb/tb_noc_output_port.sv
// Bench for noc_output_port: directed scenarios followed by randomized traffic,
// all checked against an owner-index/credit-count reference model.
module tb_noc_output_port;

  localparam int DATA_W  = 8;
  localparam int CREDITS = 4;

  logic              clk;
  logic              rst;
  logic [4:0]        req;
  logic [2:0]        sel;
  logic              enable;
  logic              credit_inc;
  logic [DATA_W-1:0] flit [5];
  logic [5*DATA_W-1:0] in_data;
  logic              port_full;
  logic [4:0]        turn;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              err;

  assign in_data = {flit[4], flit[3], flit[2], flit[1], flit[0]};

  noc_output_port #(.DATA_W(DATA_W), .CREDITS(CREDITS), .CNT_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data_i    (in_data),
    .req_i        (req),
    .port_select_i(sel),
    .port_enable_i(enable),
    .credit_inc_i (credit_inc),
    .port_full_o  (port_full),
    .turn_o       (turn),
    .data_o       (data),
    .valid_o      (valid),
    .err_o        (err)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  int                m_owner;
  int                m_credits;
  logic              m_err;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    bit legal;
    if (rst) begin
      m_owner = 0; m_credits = CREDITS; m_err = 0; m_valid = 0; m_data = '0;
    end else begin
      legal = enable && (m_credits != 0) && (sel <= 4) && (int'(sel) == m_owner);
      m_valid = legal;
      if (legal) m_data = flit[sel];
      if (legal && !credit_inc) m_credits--;
      else if (credit_inc && !legal) begin
        if (m_credits == CREDITS) m_err = 1;
        else m_credits++;
      end
      if (enable && !legal) m_err = 1;
      if (legal || !req[m_owner]) m_owner = (m_owner + 1) % 5;
    end
  endtask

  task automatic check_outputs();
    logic [4:0] exp_turn;
    exp_turn = 5'b10000 >> m_owner;
    check("valid", 32'(valid), 32'(m_valid));
    check("data",  32'(data),  32'(m_data));
    check("turn",  32'(turn),  32'(exp_turn));
    check("full",  32'(port_full), 32'(m_credits == 0));
    check("err",   32'(err),   32'(m_err));
  endtask

  // driver: apply inputs mid-cycle, step the model at the edge, sample 1ns later
  task automatic step(input logic r, input logic [4:0] rq, input logic [2:0] sl,
                      input logic en, input logic inc, input int e_val);
    @(negedge clk);
    rst = r; req = rq; sel = sl; enable = en; credit_inc = inc;
    for (int i = 0; i < 5; i++) flit[i] = DATA_W'($urandom);
    if (e_val >= 0) flit[2] = DATA_W'(e_val);
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  initial begin
    rst = 1'b1; req = '0; sel = '0; enable = 1'b0; credit_inc = 1'b0;
    for (int i = 0; i < 5; i++) flit[i] = '0;
    m_owner = 0; m_credits = CREDITS; m_err = 0; m_valid = 0; m_data = '0;

    // reset, then idle rotation through all five owners and back
    step(1, 5'b00000, 3'd0, 0, 0, -1);
    for (int i = 0; i < 7; i++) step(0, 5'b00000, 3'd0, 0, 0, -1);

    // owner is E: grant E with 8'h42
    step(0, 5'b00100, 3'd2, 1, 0, 8'h42);
    check("e_flit", 32'(data), 32'h42);
    // W, L, N grants drain the credits
    step(0, 5'b01000, 3'd3, 1, 0, -1);
    step(0, 5'b10000, 3'd4, 1, 0, -1);
    step(0, 5'b00001, 3'd0, 1, 0, -1);
    check("full_after_4", 32'(port_full), 32'd1);
    // S requesting while full holds the turn
    step(0, 5'b00010, 3'd0, 0, 0, -1);
    step(0, 5'b00010, 3'd0, 0, 0, -1);
    // two credits back, then grant plus return in the same cycle
    step(0, 5'b00010, 3'd0, 0, 1, -1);
    step(0, 5'b00010, 3'd0, 0, 1, -1);
    step(0, 5'b00010, 3'd1, 1, 1, -1);
    check("no_err_yet", 32'(err), 32'd0);

    // out-of-range select
    step(0, 5'b00000, 3'd5, 1, 0, -1);
    step(0, 5'b00000, 3'd0, 0, 0, -1);
    // wrong owner after reset
    step(1, 5'b00000, 3'd0, 0, 0, -1);
    step(0, 5'b00000, 3'd0, 0, 0, -1);
    step(0, 5'b00010, 3'd0, 1, 0, -1);
    // enable while full
    step(1, 5'b00000, 3'd0, 0, 0, -1);
    for (int i = 0; i < 4; i++) step(0, 5'b11111, 3'(m_owner), 1, 0, -1);
    step(0, 5'b11111, 3'(m_owner), 1, 0, -1);
    // saturating credit return, then reset mid-stream
    step(1, 5'b00000, 3'd0, 0, 0, -1);
    step(0, 5'b00000, 3'd0, 0, 1, -1);
    step(0, 5'b00001, 3'd0, 1, 0, -1);
    step(1, 5'b11111, 3'(m_owner), 1, 0, -1);
    check("rst_err", 32'(err), 32'd0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic r;
      logic [2:0] s;
      r = ($urandom_range(0, 39) == 0);
      s = ($urandom_range(0, 3) != 0) ? 3'(m_owner) : 3'($urandom_range(0, 7));
      step(r, 5'($urandom), s, ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 9) < 3), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
